// File: rtl/sram_ctrl_wide_pkg.sv
// Shared types and helpers for the SRAM controller family: FSM states,
// strobe polarity and word/bus geometry.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        RECOVER,
        DONE
    } state_t;

    typedef logic signed [15:0] num;

    // SRAM control pins are active low
    localparam logic PIN_ACTIVE   = 1'b0;
    localparam logic PIN_INACTIVE = 1'b1;

    function automatic int unsigned beats(input int unsigned word_w, input int unsigned bus_w);
        return word_w / bus_w;
    endfunction

endpackage

// File: rtl/sram_ctrl_wide_wait_counter.sv
// Loadable down-counter used to stretch memory strobes; tc_o is high once the
// count has reached zero and stays there until the next load.
module sram_wait_counter
    import sram_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl_wide.sv
// Asynchronous-SRAM controller: moves one WORD_W word as little-endian BUS_W
// beats with programmable wait states, per-beat write mask and registered strobes.
module sram_ctrl_wide
    import sram_pkg::*;
#(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned BUS_W       = 8,
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [WORD_W-1:0]                 req_wdata,
    input  logic [beats(WORD_W, BUS_W)-1:0]   req_be,
    output logic [WORD_W-1:0]                 rd_data,
    output logic                              rd_valid,
    output logic                              wr_done,
    output logic                              idle,
    inout  logic [BUS_W-1:0]                  sram_data,
    output logic [ADDR_W-1:0]                 sram_addr,
    output logic                              sram_ce,
    output logic                              sram_we,
    output logic                              sram_oe
);

    localparam int unsigned BEATS  = beats(WORD_W, BUS_W);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    if ((WORD_W % BUS_W) != 0 || WORD_W < BUS_W) begin : g_bad_geometry
        $error("sram_ctrl_wide: WORD_W must be a non-zero multiple of BUS_W");
    end

    state_t              state_q;
    logic                write_q;
    logic [ADDR_W-1:0]   base_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [BEATS-1:0]    be_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [WORD_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                wr_done_q;
    logic                ready_q;
    logic                ce_q;
    logic                we_q;
    logic                oe_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BUS_W-1:0]    dout_q;
    logic                drive_q;
    logic                wait_tc;

    logic [BEATS-1:0]    first_mask;
    logic [BEATS-1:0]    next_mask;
    logic                first_found;
    logic                next_found;
    int unsigned         first_idx;
    int unsigned         next_idx;

    // Reads use every beat; writes skip beats whose enable bit is clear
    always_comb begin
        first_mask  = req_write ? req_be : '1;
        next_mask   = write_q ? be_q : '1;
        first_found = 1'b0;
        first_idx   = 0;
        next_found  = 1'b0;
        next_idx    = 0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (!first_found && first_mask[k]) begin
                first_found = 1'b1;
                first_idx   = k;
            end
            if (!next_found && (k > 32'(beat_q)) && next_mask[k]) begin
                next_found = 1'b1;
                next_idx   = k;
            end
        end
    end

    sram_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (state_q != STROBE),
        .load_val_i (CNT_W'(WAIT_CYCLES)),
        .tc_o       (wait_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            beat_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            ready_q    <= 1'b1;
            ce_q       <= PIN_INACTIVE;
            we_q       <= PIN_INACTIVE;
            oe_q       <= PIN_INACTIVE;
            addr_q     <= '0;
            dout_q     <= '0;
            drive_q    <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        base_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        ready_q <= 1'b0;
                        if (first_found) begin
                            state_q <= STROBE;
                            beat_q  <= BEAT_W'(first_idx);
                            ce_q    <= PIN_ACTIVE;
                            addr_q  <= req_addr + ADDR_W'(first_idx);
                            if (req_write) begin
                                we_q    <= PIN_ACTIVE;
                                drive_q <= 1'b1;
                                dout_q  <= req_wdata[first_idx*BUS_W +: BUS_W];
                            end else begin
                                oe_q <= PIN_ACTIVE;
                            end
                        end else begin
                            state_q   <= DONE;
                            wr_done_q <= 1'b1;
                        end
                    end
                end
                STROBE: begin
                    if (wait_tc) begin
                        state_q <= RECOVER;
                        we_q    <= PIN_INACTIVE;
                        oe_q    <= PIN_INACTIVE;
                        if (!write_q) begin
                            rd_data_q[beat_q*BUS_W +: BUS_W] <= sram_data;
                        end
                    end
                end
                RECOVER: begin
                    if (next_found) begin
                        state_q <= STROBE;
                        beat_q  <= BEAT_W'(next_idx);
                        addr_q  <= base_q + ADDR_W'(next_idx);
                        if (write_q) begin
                            we_q   <= PIN_ACTIVE;
                            dout_q <= wdata_q[next_idx*BUS_W +: BUS_W];
                        end else begin
                            oe_q <= PIN_ACTIVE;
                        end
                    end else begin
                        state_q    <= DONE;
                        ce_q       <= PIN_INACTIVE;
                        drive_q    <= 1'b0;
                        wr_done_q  <= write_q;
                        rd_valid_q <= !write_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    beat_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign idle      = ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_done   = wr_done_q;
    assign sram_addr = addr_q;
    assign sram_ce   = ce_q;
    assign sram_we   = we_q;
    assign sram_oe   = oe_q;
    assign sram_data = drive_q ? dout_q : 'z;

endmodule

// File: tb/tb_sram_ctrl_wide.sv
// Directed bench for sram_ctrl_wide: default 16/8 controller plus a 32-bit,
// zero-wait-state instance, each against a small byte-wide SRAM model.
module tb_sram_ctrl_wide;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_valid, a_ready, a_write, a_rv, a_wd, a_idle, a_ce, a_we, a_oe;
    logic [20:0] a_addr, a_saddr;
    logic [15:0] a_wdata, a_rdata;
    logic [1:0]  a_be;
    tri1  [7:0]  a_bus;

    logic        b_valid, b_ready, b_write, b_rv, b_wd, b_idle, b_ce, b_we, b_oe;
    logic [20:0] b_addr, b_saddr;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_be;
    tri1  [7:0]  b_bus;

    sram_ctrl_wide u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .rd_data(a_rdata), .rd_valid(a_rv), .wr_done(a_wd), .idle(a_idle),
        .sram_data(a_bus), .sram_addr(a_saddr),
        .sram_ce(a_ce), .sram_we(a_we), .sram_oe(a_oe)
    );

    sram_ctrl_wide #(
        .WORD_W(32), .BUS_W(8), .ADDR_W(21), .WAIT_CYCLES(0)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .rd_data(b_rdata), .rd_valid(b_rv), .wr_done(b_wd), .idle(b_idle),
        .sram_data(b_bus), .sram_addr(b_saddr),
        .sram_ce(b_ce), .sram_we(b_we), .sram_oe(b_oe)
    );

    // Byte-wide SRAM models, indexed by the low address byte
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic       pl_en, pl_sel;
    logic [7:0] pl_idx, pl_data;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem_a[pl_idx] <= pl_data;
        else if (!a_ce && !a_we) mem_a[a_saddr[7:0]] <= a_bus;
        if (pl_en && pl_sel) mem_b[pl_idx] <= pl_data;
        else if (!b_ce && !b_we) mem_b[b_saddr[7:0]] <= b_bus;
    end

    assign a_bus = (!a_ce && !a_oe) ? mem_a[a_saddr[7:0]] : 'z;
    assign b_bus = (!b_ce && !b_oe) ? mem_b[b_saddr[7:0]] : 'z;

    // Bus activity log sampled mid-cycle
    logic [28:0] a_wlog [$];
    logic [20:0] a_rlog [$];
    int a_drv_n = 0, a_rv_n = 0, a_wd_n = 0, b_oe_n = 0;

    always @(negedge clk) begin
        if (!a_ce && !a_we) a_wlog.push_back({a_saddr, a_bus});
        if (!a_ce && !a_oe) a_rlog.push_back(a_saddr);
        if (!(!a_ce && !a_oe) && a_bus !== 8'hFF) a_drv_n++;
        if (a_rv) a_rv_n++;
        if (a_wd) a_wd_n++;
        if (!b_ce && !b_oe) b_oe_n++;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic sel, input logic [7:0] idx, input logic [7:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_sel = sel; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request on DUT A from IDLE; lat = accept edge to pulse cycle
    task automatic a_req(input logic wr, input logic [20:0] ad, input logic [15:0] wd,
                         input logic [1:0] be, output int lat);
        @(negedge clk);
        a_valid = 1'b1; a_write = wr; a_addr = ad; a_wdata = wd; a_be = be;
        @(posedge clk);
        #1 a_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (a_rv || a_wd) break;
            lat++;
        end
    endtask

    int lat, n0, r0, d0, v0, w0, g;

    initial begin
        pl_en = 1'b0; pl_sel = 1'b0; pl_idx = '0; pl_data = '0;
        a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_ready", 64'(a_ready), 64'd1);
        chk("rst_idle",  64'(a_idle),  64'd1);
        chk("rst_pins",  64'({a_ce, a_we, a_oe}), 64'b111);
        chk("rst_addr",  64'(a_saddr), 64'd0);
        chk("rst_rdata", 64'(a_rdata), 64'd0);
        chk("rst_pulse", 64'({a_rv, a_wd}), 64'd0);
        chk("rst_bus",   64'(a_bus),   64'hFF);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 64'(a_idle), 64'd1);

        // Full-mask write, default timing
        n0 = a_wlog.size();
        a_req(1'b1, 21'h00010, 16'hBEEF, 2'b11, lat);
        chk("wr_lat", 64'(lat), 64'd6);
        chk("wr_done_ready_low", 64'(a_ready), 64'd0);
        chk("wr_log_n", 64'(a_wlog.size() - n0), 64'd4);
        chk("wr_beat0a", 64'(a_wlog[n0]),   64'({21'h00010, 8'hEF}));
        chk("wr_beat0b", 64'(a_wlog[n0+1]), 64'({21'h00010, 8'hEF}));
        chk("wr_beat1a", 64'(a_wlog[n0+2]), 64'({21'h00011, 8'hBE}));
        chk("wr_beat1b", 64'(a_wlog[n0+3]), 64'({21'h00011, 8'hBE}));
        @(negedge clk);
        chk("wr_pulse_end", 64'(a_wd), 64'd0);
        chk("wr_ready_back", 64'({a_ready, a_idle}), 64'b11);
        chk("mem_10", 64'(mem_a[8'h10]), 64'hEF);
        chk("mem_11", 64'(mem_a[8'h11]), 64'hBE);

        // Read across the top of the address space
        preload(1'b0, 8'hFF, 8'h34);
        preload(1'b0, 8'h00, 8'h12);
        n0 = a_wlog.size(); r0 = a_rlog.size(); d0 = a_drv_n; v0 = a_rv_n;
        a_req(1'b0, 21'h1FFFFF, 16'h0000, 2'b00, lat);
        chk("rd_lat", 64'(lat), 64'd6);
        chk("rd_data", 64'(a_rdata), 64'h1234);
        chk("rd_addr0", 64'(a_rlog[r0]),   64'h1FFFFF);
        chk("rd_addr1", 64'(a_rlog[r0+2]), 64'h000000);
        chk("rd_strobes", 64'(a_rlog.size() - r0), 64'd4);
        @(negedge clk);
        chk("rd_pulse_end", 64'(a_rv), 64'd0);
        chk("rd_pulse_cnt", 64'(a_rv_n - v0), 64'd1);
        chk("rd_no_we", 64'(a_wlog.size() - n0), 64'd0);
        chk("rd_no_drive", 64'(a_drv_n - d0), 64'd0);

        // Upper-beat-only write
        preload(1'b0, 8'h20, 8'h55);
        n0 = a_wlog.size();
        a_req(1'b1, 21'h00020, 16'hAABB, 2'b10, lat);
        chk("be10_lat", 64'(lat), 64'd3);
        chk("be10_log_n", 64'(a_wlog.size() - n0), 64'd2);
        chk("be10_beat", 64'(a_wlog[n0]), 64'({21'h00021, 8'hAA}));
        @(negedge clk);
        chk("be10_mem20", 64'(mem_a[8'h20]), 64'h55);
        chk("be10_mem21", 64'(mem_a[8'h21]), 64'hAA);

        // Empty mask
        n0 = a_wlog.size(); r0 = a_rlog.size();
        a_req(1'b1, 21'h00030, 16'h1111, 2'b00, lat);
        chk("be00_lat", 64'(lat), 64'd0);
        chk("be00_ce", 64'(a_ce), 64'd1);
        chk("be00_no_strobe", 64'(a_wlog.size() - n0 + a_rlog.size() - r0), 64'd0);

        // 32-bit word, zero wait states
        preload(1'b1, 8'h00, 8'h11);
        preload(1'b1, 8'h01, 8'h22);
        preload(1'b1, 8'h02, 8'h33);
        preload(1'b1, 8'h03, 8'h44);
        v0 = b_oe_n;
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b0; b_addr = 21'h00100;
        @(posedge clk);
        #1 b_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (b_rv) break;
            lat++;
        end
        chk("b_lat", 64'(lat), 64'd8);
        chk("b_rdata", 64'(b_rdata), 64'h44332211);
        chk("b_strobe_cycles", 64'(b_oe_n - v0), 64'd4);

        // req_valid held high: accepts spaced by busy period plus one
        n0 = a_wlog.size();
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 21'h00040; a_wdata = 16'h0102; a_be = 2'b11;
        g = 0;
        while (g < 40) begin
            @(negedge clk);
            if (a_wd) break;
            g++;
        end
        chk("hold_done_ready", 64'(a_ready), 64'd0);
        g = 0;
        while (g < 40) begin
            @(negedge clk);
            g++;
            if (a_wd) break;
        end
        a_valid = 1'b0;
        chk("hold_gap", 64'(g), 64'd8);
        chk("hold_strobes", 64'(a_wlog.size() - n0), 64'd8);
        repeat (2) @(negedge clk);
        chk("hold_idle", 64'(a_idle), 64'd1);

        // Reset during the second write strobe
        w0 = a_wd_n;
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 21'h00050; a_wdata = 16'h1357; a_be = 2'b11;
        @(posedge clk);
        #1 a_valid = 1'b0;
        g = 0;
        while (g < 40) begin
            @(negedge clk);
            if (a_saddr == 21'h00051 && !a_we) break;
            g++;
        end
        chk("abort_found_beat1", 64'(g < 40), 64'd1);
        chk("abort_bus_before", 64'(a_bus), 64'h13);
        #2 reset = 1'b1;
        #1;
        chk("abort_pins", 64'({a_ce, a_we, a_oe}), 64'b111);
        chk("abort_bus", 64'(a_bus), 64'hFF);
        chk("abort_rdata", 64'(a_rdata), 64'd0);
        chk("abort_b_rdata", 64'(b_rdata), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", 64'(a_wd_n - w0), 64'd0);
        chk("abort_idle", 64'({a_idle, a_ready}), 64'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
